row_output_accumulator: RTL and testbench

// Producer side of the vector-by-scalar normalisation interface. Accumulates one attention row:
// o += p*v per key and l += p, where p is the exp score and v is the V row. At row end it holds
// (o, l) on vec_out/divisor_out under vld/rdy until the vector_division stage accepts them.

---
 rtl/row_output_accumulator.sv | 136 +++++++++++++
 tb/tb_row_output_accumulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/row_output_accumulator.sv
// Accumulates o += p*v and l += p over one attention row, then offers the narrowed (o, l) to the divider.
// Latency: vld_out rises 1 cycle after the closing beat; one bubble cycle per row after the handshake.
// Backpressure: holds outputs in DRAIN until rdy_in; rdy_out=0 there. Optional macro ROW_ACC_SATURATE_EN.
module row_output_accumulator #(
    parameter int VEC_LEN    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int MAX_KEYS   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    output logic                          rdy_out,
    input  logic [DATA_WIDTH-1:0]         p_in,
    input  logic [VEC_LEN*DATA_WIDTH-1:0] v_in,
    input  logic                          last_in,
    output logic                          vld_out,
    input  logic                          rdy_in,
    output logic [VEC_LEN*DATA_WIDTH-1:0] vec_out,
    output logic [DATA_WIDTH-1:0]         divisor_out,
    output logic                          ovf_out
);
    localparam int CW = $clog2(MAX_KEYS+1);
    localparam int PAD = ACC_WIDTH - 2*DATA_WIDTH;

    typedef enum logic {ACCUM, DRAIN} state_t;
    state_t state;

    logic [ACC_WIDTH-1:0] o_acc [VEC_LEN];
    logic [ACC_WIDTH-1:0] l_acc;
    logic                 first;
    logic                 sat_q;
    logic [CW-1:0]        cnt;

    logic [ACC_WIDTH-1:0]    o_nxt [VEC_LEN];
    logic [ACC_WIDTH:0]      o_sum [VEC_LEN];
    logic [2*DATA_WIDTH-1:0] prod  [VEC_LEN];
    logic [ACC_WIDTH-1:0]    l_nxt;
    logic [ACC_WIDTH:0]      l_sum;
    logic                    sat_nxt;
    logic [VEC_LEN*DATA_WIDTH-1:0] vec_nar;
    logic [DATA_WIDTH-1:0]   l_nar;
    logic                    ovf_nxt;
    logic [CW-1:0]           cnt_inc;
    logic                    row_close;

    always_comb begin
        sat_nxt = first ? 1'b0 : sat_q;
        ovf_nxt = 1'b0;
        vec_nar = '0;
        // first beat of a row overwrites the accumulators, so stale values never leak in
        l_sum = {1'b0, (first ? {ACC_WIDTH{1'b0}} : l_acc)} + {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, p_in};
        l_nxt = l_sum[ACC_WIDTH-1:0];
`ifdef ROW_ACC_SATURATE_EN
        if (l_sum[ACC_WIDTH]) begin
            l_nxt   = '1;
            sat_nxt = 1'b1;
        end
`endif
        for (int i = 0; i < VEC_LEN; i++) begin
            prod[i]  = {{DATA_WIDTH{1'b0}}, p_in} * {{DATA_WIDTH{1'b0}}, v_in[i*DATA_WIDTH +: DATA_WIDTH]};
            o_sum[i] = {1'b0, (first ? {ACC_WIDTH{1'b0}} : o_acc[i])} + {1'b0, {PAD{1'b0}}, prod[i]};
            o_nxt[i] = o_sum[i][ACC_WIDTH-1:0];
`ifdef ROW_ACC_SATURATE_EN
            if (o_sum[i][ACC_WIDTH]) begin
                o_nxt[i] = '1;
                sat_nxt  = 1'b1;
            end
`endif
            vec_nar[i*DATA_WIDTH +: DATA_WIDTH] = o_nxt[i][DATA_WIDTH-1:0];
            if (o_nxt[i][ACC_WIDTH-1:DATA_WIDTH] != '0) begin
                ovf_nxt = 1'b1;
`ifdef ROW_ACC_SATURATE_EN
                vec_nar[i*DATA_WIDTH +: DATA_WIDTH] = '1;
`endif
            end
        end
        l_nar = l_nxt[DATA_WIDTH-1:0];
        if (l_nxt[ACC_WIDTH-1:DATA_WIDTH] != '0) begin
            ovf_nxt = 1'b1;
`ifdef ROW_ACC_SATURATE_EN
            l_nar = '1;
`endif
        end
        ovf_nxt = ovf_nxt | sat_nxt;
    end

    assign cnt_inc   = cnt + 1'b1;
    assign row_close = last_in || (cnt_inc == CW'(MAX_KEYS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ACCUM;
            for (int i = 0; i < VEC_LEN; i++) o_acc[i] <= '0;
            l_acc       <= '0;
            first       <= 1'b1;
            sat_q       <= 1'b0;
            cnt         <= '0;
            vld_out     <= 1'b0;
            rdy_out     <= 1'b1;
            vec_out     <= '0;
            divisor_out <= '0;
            ovf_out     <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (vld_in) begin
                        for (int i = 0; i < VEC_LEN; i++) o_acc[i] <= o_nxt[i];
                        l_acc <= l_nxt;
                        sat_q <= sat_nxt;
                        first <= 1'b0;
                        cnt   <= cnt_inc;
                        if (row_close) begin
                            state       <= DRAIN;
                            vld_out     <= 1'b1;
                            rdy_out     <= 1'b0;
                            vec_out     <= vec_nar;
                            divisor_out <= l_nar;
                            ovf_out     <= ovf_nxt;
                        end
                    end
                end
                DRAIN: begin
                    if (rdy_in) begin
                        state   <= ACCUM;
                        vld_out <= 1'b0;
                        rdy_out <= 1'b1;
                        first   <= 1'b1;
                        cnt     <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_row_output_accumulator.sv
// Scoreboard bench for row_output_accumulator: stimulus pushes expected rows, a monitor checks each handshake.
module tb_row_output_accumulator;
    localparam int VL = 4;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             vld_in = 1'b0;
    logic             rdy_out;
    logic [DW-1:0]    p_in = '0;
    logic [VL*DW-1:0] v_in = '0;
    logic             last_in = 1'b0;
    logic             vld_out;
    logic             rdy_in = 1'b1;
    logic [VL*DW-1:0] vec_out;
    logic [DW-1:0]    divisor_out;
    logic             ovf_out;

    row_output_accumulator #(.VEC_LEN(VL), .DATA_WIDTH(DW), .ACC_WIDTH(24), .MAX_KEYS(4)) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .p_in(p_in), .v_in(v_in),
        .last_in(last_in), .vld_out(vld_out), .rdy_in(rdy_in), .vec_out(vec_out),
        .divisor_out(divisor_out), .ovf_out(ovf_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VL*DW-1:0] vec;
        logic [DW-1:0]    div;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] v4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic push(input logic [31:0] vec, input int div, input logic ovf);
        exp_t e;
        e.vec = vec;
        e.div = div[7:0];
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // monitor: a handshake completes at the next rising edge
    always @(negedge clk) begin
        if (rst && vld_out && rdy_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row: got vec %0h div %0h with nothing expected", vec_out, divisor_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("row_vec", vec_out, e.vec);
                chk("row_div", {24'd0, divisor_out}, {24'd0, e.div});
                chk("row_ovf", {31'd0, ovf_out}, {31'd0, e.ovf});
            end
        end
    end

    task automatic beat(input int p, input logic [31:0] v, input logic last);
        chk("beat_rdy_out", {31'd0, rdy_out}, 32'd1);
        vld_in  = 1'b1;
        p_in    = p[7:0];
        v_in    = v;
        last_in = last;
        @(posedge clk);
        #1;
        vld_in  = 1'b0;
        last_in = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vld_out", {31'd0, vld_out}, 32'd0);
        chk("reset_rdy_out", {31'd0, rdy_out}, 32'd1);
        chk("reset_vec_out", vec_out, 32'd0);
        chk("reset_div_out", {24'd0, divisor_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // basic row, vld_out exactly one cycle after closing beat
        beat(2, v4(1, 2, 3, 4), 1'b0);
        push(v4(5, 7, 9, 11), 5, 1'b0);
        beat(3, v4(1, 1, 1, 1), 1'b1);
        chk("latency_vld_out", {31'd0, vld_out}, 32'd1);
        wait_drained();
        chk("post_hs_rdy_out", {31'd0, rdy_out}, 32'd1);

        // backpressure: outputs hold, beats dropped
        rdy_in = 1'b0;
        beat(2, v4(1, 2, 3, 4), 1'b0);
        push(v4(5, 7, 9, 11), 5, 1'b0);
        beat(3, v4(1, 1, 1, 1), 1'b1);
        for (int i = 0; i < 3; i++) begin
            vld_in = 1'b1;
            p_in = 8'd7;
            v_in = v4(9, 9, 9, 9);
            last_in = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_rdy_out", {31'd0, rdy_out}, 32'd0);
            chk("bp_vld_out", {31'd0, vld_out}, 32'd1);
            chk("bp_vec_hold", vec_out, v4(5, 7, 9, 11));
        end
        vld_in = 1'b0;
        last_in = 1'b0;
        rdy_in = 1'b1;
        wait_drained();
        chk("bp_release_rdy_out", {31'd0, rdy_out}, 32'd1);
        chk("bp_release_vld_out", {31'd0, vld_out}, 32'd0);

        // zero row
        push(v4(0, 0, 0, 0), 0, 1'b0);
        beat(0, v4(9, 9, 9, 9), 1'b1);
        wait_drained();

        // overflow
`ifdef ROW_ACC_SATURATE_EN
        push(v4(255, 255, 255, 255), 255, 1'b1);
`else
        push(v4(2, 2, 2, 2), 254, 1'b1);
`endif
        beat(255, v4(255, 255, 255, 255), 1'b0);
        beat(255, v4(255, 255, 255, 255), 1'b1);
        wait_drained();

        // force close at MAX_KEYS, then a fresh row
        push(v4(4, 4, 4, 4), 4, 1'b0);
        for (int i = 0; i < 4; i++) beat(1, v4(1, 1, 1, 1), 1'b0);
        chk("force_close_vld_out", {31'd0, vld_out}, 32'd1);
        wait_drained();
        push(v4(6, 0, 0, 2), 2, 1'b0);
        beat(2, v4(3, 0, 0, 1), 1'b1);
        wait_drained();

        // reset during DRAIN discards the row
        rdy_in = 1'b0;
        beat(5, v4(7, 7, 7, 7), 1'b1);
        hold = vec_out;
        chk("pre_reset_vec", hold, v4(35, 35, 35, 35));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_drain_vld_out", {31'd0, vld_out}, 32'd0);
        chk("rst_drain_rdy_out", {31'd0, rdy_out}, 32'd1);
        chk("rst_drain_vec_out", vec_out, 32'd0);
        rdy_in = 1'b1;
        push(v4(1, 2, 3, 4), 1, 1'b0);
        beat(1, v4(1, 2, 3, 4), 1'b1);
        wait_drained();

        repeat (3) @(posedge clk);
        #1;
        chk("idle_vld_out", {31'd0, vld_out}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
